// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32I main control decoder plus the control/rd pipeline
// registers for ID/EX, EX/MEM and MEM/WB, with load-use hazard detection
// and bubble insertion.
//
// Ports:
//   clk, rst_n              rising-edge clock, async active-low reset
//   id_valid                IF/ID holds a real instruction (0 = bubble)
//   id_opcode/rs1/rs2/rd    instruction fields from the IF/ID register
//   flush                   taken branch/jump in EX; squash the ID instruction
//   stall_ext               memory wait; freeze all three pipeline registers
//   hazard_stall            load-use hazard detected (combinational)
//   pc_we, ifid_we          PC and IF/ID write enables
//   ex_/mem_/wb_ctrl        registered control bundles
//   ex_/mem_/wb_rd          registered destination register addresses
//
// Valid/ready: there is no backpressure handshake. The pipeline advances on
// every clock edge where stall_ext is low; an edge with stall_ext high holds
// every register. Empty slots are all-zero bubbles.
//
// Bundle layout, MSB to LSB: illegal, pc_rel, upper, jalr, alu_src,
// mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op.
module ctrl_pipe #(
    parameter  int ALUOP_W = 3,
    parameter  int REG_AW  = 5,
    localparam int CTRL_W  = 11 + ALUOP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    input  logic              stall_ext,
    output logic              hazard_stall,
    output logic              pc_we,
    output logic              ifid_we,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd
);

    // Bit position of mem_read inside the bundle.
    localparam int B_MEM_READ = ALUOP_W + 3;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]        fields;   // alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump
    logic [2:0]        alu_op3;
    logic              illegal;
    logic              pc_rel;
    logic              upper;
    logic              jalr;
    logic              uses_rs1;
    logic              uses_rs2;
    logic [CTRL_W-1:0] dec_ctrl;

    always_comb begin
        fields   = 7'b0000000;
        alu_op3  = 3'b000;
        illegal  = 1'b0;
        pc_rel   = 1'b0;
        upper    = 1'b0;
        jalr     = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            OP_R: begin
                fields   = 7'b0010000;
                alu_op3  = 3'b010;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                fields   = 7'b1111000;
                uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                fields   = 7'b1000100;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BR: begin
                fields   = 7'b0000010;
                alu_op3  = 3'b001;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IALU: begin
                fields   = 7'b1010000;
                alu_op3  = 3'b011;
                uses_rs1 = 1'b1;
            end
            OP_JALR: begin
                fields   = 7'b1010001;
                jalr     = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_JAL: begin
                fields   = 7'b1010001;
            end
            OP_LUI: begin
                fields   = 7'b1010000;
                alu_op3  = 3'b100;
                upper    = 1'b1;
            end
            OP_AUIPC: begin
                fields   = 7'b1010000;
                pc_rel   = 1'b1;
            end
            default: begin
                illegal  = 1'b1;
            end
        endcase
        // Upper alu_op bits are zero when ALUOP_W is wider than 3.
        dec_ctrl = {illegal, pc_rel, upper, jalr, fields, ALUOP_W'(alu_op3)};
    end

    // ------------------------------------------------------------------
    // Hazard detection and enables
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic [CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;
    logic [CTRL_W-1:0] wb_ctrl_q,  wb_ctrl_d;
    logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
    logic [REG_AW-1:0] mem_rd_q,   mem_rd_d;
    logic [REG_AW-1:0] wb_rd_q,    wb_rd_d;
    logic              insert_bubble;

    // x0 never carries a real value, so a load into x0 creates no dependency.
    assign hazard_stall = id_valid & ex_ctrl_q[B_MEM_READ] & (ex_rd_q != '0)
                        & ((uses_rs1 & (ex_rd_q == id_rs1))
                         | (uses_rs2 & (ex_rd_q == id_rs2)));

    // A flush overrides the load-use stall so the redirect can proceed.
    assign pc_we   = ~stall_ext & ~(hazard_stall & ~flush);
    assign ifid_we = pc_we;

    assign insert_bubble = flush | hazard_stall | ~id_valid;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_rd_d   = mem_rd_q;
        wb_ctrl_d  = wb_ctrl_q;
        wb_rd_d    = wb_rd_q;
        if (!stall_ext) begin
            if (insert_bubble) begin
                ex_ctrl_d = '0;
                ex_rd_d   = '0;
            end else begin
                ex_ctrl_d = dec_ctrl;
                ex_rd_d   = id_rd;
            end
            mem_ctrl_d = ex_ctrl_q;
            mem_rd_d   = ex_rd_q;
            wb_ctrl_d  = mem_ctrl_q;
            wb_rd_d    = mem_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q  <= '0;
            ex_rd_q    <= '0;
            mem_ctrl_q <= '0;
            mem_rd_q   <= '0;
            wb_ctrl_q  <= '0;
            wb_rd_q    <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_rd_q   <= mem_rd_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign ex_ctrl  = ex_ctrl_q;
    assign mem_ctrl = mem_ctrl_q;
    assign wb_ctrl  = wb_ctrl_q;
    assign ex_rd    = ex_rd_q;
    assign mem_rd   = mem_rd_q;
    assign wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed test for ctrl_pipe. The driver issues one ID-stage
// instruction per cycle and pushes the hand-computed ID/EX contents into
// exp_q; the monitor pops on every advancing clock edge and tracks the
// expected EX, MEM and WB contents to compare against the DUT.
module tb_ctrl_pipe;

    localparam int CW = 14;
    localparam int AW = 5;
    localparam int W  = CW + AW;

    // Expected bundles: illegal pc_rel upper jalr | alu_src m2r rw mr mw br j | alu_op
    localparam logic [CW-1:0] C_R     = 14'b0000_0010000_010;
    localparam logic [CW-1:0] C_LD    = 14'b0000_1111000_000;
    localparam logic [CW-1:0] C_ST    = 14'b0000_1000100_000;
    localparam logic [CW-1:0] C_BR    = 14'b0000_0000010_001;
    localparam logic [CW-1:0] C_IALU  = 14'b0000_1010000_011;
    localparam logic [CW-1:0] C_JALR  = 14'b0001_1010001_000;
    localparam logic [CW-1:0] C_JAL   = 14'b0000_1010001_000;
    localparam logic [CW-1:0] C_LUI   = 14'b0010_1010000_100;
    localparam logic [CW-1:0] C_AUIPC = 14'b0100_1010000_000;
    localparam logic [CW-1:0] C_ILL   = 14'b1000_0000000_000;
    localparam logic [CW-1:0] C_BUB   = 14'b0;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [6:0]    id_opcode;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          flush;
    logic          stall_ext;
    logic          hazard_stall, pc_we, ifid_we;
    logic [CW-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e_ex  = '0;
    logic [W-1:0] e_mem = '0;
    logic [W-1:0] e_wb  = '0;
    int total = 0;
    int bad   = 0;

    ctrl_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .flush        (flush),
        .stall_ext    (stall_ext),
        .hazard_stall (hazard_stall),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ex_ctrl      (ex_ctrl),
        .mem_ctrl     (mem_ctrl),
        .wb_ctrl      (wb_ctrl),
        .ex_rd        (ex_rd),
        .mem_rd       (mem_rd),
        .wb_rd        (wb_rd)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helper ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic v, input logic [6:0] op, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input logic [AW-1:0] rd,
                         input logic fl, input logic st,
                         input logic [CW-1:0] ec, input logic [AW-1:0] erd,
                         input logic eh, input string nm);
        logic ew;
        @(negedge clk);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = rd;
        flush     = fl;
        stall_ext = st;
        #1;
        ew = !st && !(eh && !fl);
        check({nm, " hazard"}, 32'(hazard_stall), 32'(eh));
        check({nm, " pc_we"}, 32'(pc_we), 32'(ew));
        check({nm, " ifid_we"}, 32'(ifid_we), 32'(ew));
        if (!st) exp_q.push_back({ec, erd});
    endtask

    task automatic bubble();
        issue(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_BUB, 5'd0, 1'b0, "bubble");
    endtask

    // Releases reset at a falling edge together with a bubble in ID, so the
    // next rising edge is the first advancing one.
    task automatic release_reset();
        @(negedge clk);
        id_valid  = 1'b0;
        flush     = 1'b0;
        stall_ext = 1'b0;
        rst_n     = 1'b1;
        exp_q.push_back('0);
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, " ex"},  32'({ex_ctrl, ex_rd}), 32'(0));
        check({nm, " mem"}, 32'({mem_ctrl, mem_rd}), 32'(0));
        check({nm, " wb"},  32'({wb_ctrl, wb_rd}), 32'(0));
        check({nm, " hazard"}, 32'(hazard_stall), 32'(0));
        check({nm, " pc_we"}, 32'(pc_we), 32'(1));
        check({nm, " ifid_we"}, 32'(ifid_we), 32'(1));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge rst_n) begin
        e_ex  = '0;
        e_mem = '0;
        e_wb  = '0;
        exp_q.delete();
    end

    always @(posedge clk) begin
        logic live, adv;
        live = rst_n;
        adv  = rst_n && !stall_ext;
        #1;
        if (live && rst_n) begin
            if (adv) begin
                e_wb  = e_mem;
                e_mem = e_ex;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL underflow: got empty queue want an entry (t=%0t)", $time);
                    e_ex = '0;
                end else begin
                    e_ex = exp_q.pop_front();
                end
            end
            check("ex stage",  32'({ex_ctrl, ex_rd}), 32'(e_ex));
            check("mem stage", 32'({mem_ctrl, mem_rd}), 32'(e_mem));
            check("wb stage",  32'({wb_ctrl, wb_rd}), 32'(e_wb));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        id_valid  = 1'b0;
        id_opcode = 7'b0;
        id_rs1    = '0;
        id_rs2    = '0;
        id_rd     = '0;
        flush     = 1'b0;
        stall_ext = 1'b0;
        #2;
        check_reset_state("reset");
        release_reset();

        // Decode sweep
        issue(1, OP_R,     5'd2,  5'd3, 5'd1,  0, 0, C_R,     5'd1,  0, "R");
        issue(1, OP_LD,    5'd2,  5'd0, 5'd4,  0, 0, C_LD,    5'd4,  0, "load");
        issue(1, OP_ST,    5'd5,  5'd6, 5'd17, 0, 0, C_ST,    5'd17, 0, "store");
        issue(1, OP_BR,    5'd7,  5'd8, 5'd18, 0, 0, C_BR,    5'd18, 0, "branch");
        issue(1, OP_IALU,  5'd10, 5'd0, 5'd9,  0, 0, C_IALU,  5'd9,  0, "ialu");
        issue(1, OP_JALR,  5'd12, 5'd0, 5'd11, 0, 0, C_JALR,  5'd11, 0, "jalr");
        issue(1, OP_JAL,   5'd0,  5'd0, 5'd13, 0, 0, C_JAL,   5'd13, 0, "jal");
        issue(1, OP_LUI,   5'd0,  5'd0, 5'd14, 0, 0, C_LUI,   5'd14, 0, "lui");
        issue(1, OP_AUIPC, 5'd0,  5'd0, 5'd15, 0, 0, C_AUIPC, 5'd15, 0, "auipc");
        issue(1, OP_BAD,   5'd0,  5'd0, 5'd16, 0, 0, C_ILL,   5'd16, 0, "illegal");
        repeat (3) bubble();

        // Load-use: lw x5; add x6,x5,x7 stalls one cycle
        issue(1, OP_LD,    5'd1,  5'd0, 5'd5,  0, 0, C_LD,    5'd5,  0, "lw x5");
        issue(1, OP_R,     5'd5,  5'd7, 5'd6,  0, 0, C_BUB,   5'd0,  1, "add stall");
        issue(1, OP_R,     5'd5,  5'd7, 5'd6,  0, 0, C_R,     5'd6,  0, "add retry");
        // lui x5 after lw x5: lui reads no source register
        issue(1, OP_LD,    5'd1,  5'd0, 5'd5,  0, 0, C_LD,    5'd5,  0, "lw x5 b");
        issue(1, OP_LUI,   5'd5,  5'd5, 5'd5,  0, 0, C_LUI,   5'd5,  0, "lui x5");
        // lw x0 then a user of x0
        issue(1, OP_LD,    5'd1,  5'd0, 5'd0,  0, 0, C_LD,    5'd0,  0, "lw x0");
        issue(1, OP_R,     5'd0,  5'd0, 5'd1,  0, 0, C_R,     5'd1,  0, "add x0");
        // Dependency through rs2 only
        issue(1, OP_LD,    5'd1,  5'd0, 5'd8,  0, 0, C_LD,    5'd8,  0, "lw x8");
        issue(1, OP_ST,    5'd1,  5'd8, 5'd0,  0, 0, C_BUB,   5'd0,  1, "sw stall");
        issue(1, OP_ST,    5'd1,  5'd8, 5'd0,  0, 0, C_ST,    5'd0,  0, "sw retry");
        // jal does not read rs1 even if its bits match the load target
        issue(1, OP_LD,    5'd1,  5'd0, 5'd9,  0, 0, C_LD,    5'd9,  0, "lw x9");
        issue(1, OP_JAL,   5'd9,  5'd9, 5'd1,  0, 0, C_JAL,   5'd1,  0, "jal nostall");

        // Flush
        issue(1, OP_R,     5'd2,  5'd3, 5'd4,  1, 0, C_BUB,   5'd0,  0, "flush R");
        issue(1, OP_LD,    5'd1,  5'd0, 5'd9,  0, 0, C_LD,    5'd9,  0, "lw x9 b");
        issue(1, OP_R,     5'd9,  5'd3, 5'd4,  1, 0, C_BUB,   5'd0,  1, "flush+hazard");
        bubble();

        // External stall with a load in EX and its user in ID
        issue(1, OP_R,     5'd1,  5'd2, 5'd20, 0, 0, C_R,     5'd20, 0, "R x20");
        issue(1, OP_IALU,  5'd3,  5'd0, 5'd22, 0, 0, C_IALU,  5'd22, 0, "ialu x22");
        issue(1, OP_LD,    5'd4,  5'd0, 5'd21, 0, 0, C_LD,    5'd21, 0, "lw x21");
        issue(1, OP_R,     5'd21, 5'd5, 5'd23, 0, 1, C_BUB,   5'd0,  1, "stall 1");
        issue(1, OP_R,     5'd21, 5'd5, 5'd23, 1, 1, C_BUB,   5'd0,  1, "stall 2 flush");
        issue(1, OP_R,     5'd21, 5'd5, 5'd23, 0, 1, C_BUB,   5'd0,  1, "stall 3");
        issue(1, OP_R,     5'd21, 5'd5, 5'd23, 0, 0, C_BUB,   5'd0,  1, "post stall hz");
        issue(1, OP_R,     5'd21, 5'd5, 5'd23, 0, 0, C_R,     5'd23, 0, "post stall add");

        // Back-to-back stream
        issue(1, OP_LD,    5'd2,  5'd0, 5'd1,  0, 0, C_LD,    5'd1,  0, "s lw");
        issue(1, OP_ST,    5'd3,  5'd4, 5'd2,  0, 0, C_ST,    5'd2,  0, "s sw");
        issue(1, OP_BR,    5'd5,  5'd6, 5'd3,  0, 0, C_BR,    5'd3,  0, "s beq");
        issue(1, OP_JAL,   5'd0,  5'd0, 5'd7,  0, 0, C_JAL,   5'd7,  0, "s jal");
        issue(1, OP_AUIPC, 5'd0,  5'd0, 5'd8,  0, 0, C_AUIPC, 5'd8,  0, "s auipc");
        repeat (3) bubble();

        // Asynchronous reset mid-cycle with instructions in flight
        issue(1, OP_R,     5'd1,  5'd2, 5'd11, 0, 0, C_R,     5'd11, 0, "r R");
        issue(1, OP_IALU,  5'd1,  5'd0, 5'd12, 0, 0, C_IALU,  5'd12, 0, "r ialu");
        issue(1, OP_LD,    5'd1,  5'd0, 5'd10, 0, 0, C_LD,    5'd10, 0, "r lw");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid reset");
        release_reset();
        issue(1, OP_LUI,   5'd0,  5'd0, 5'd3,  0, 0, C_LUI,   5'd3,  0, "after reset");
        repeat (3) bubble();

        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised successor to the single-cycle main control decoder.
- Decodes the full RV32I base opcode set, including lui/auipc, with an explicit illegal flag instead of don't-care outputs.
- Carries the control bundle plus rd through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Generates the load-use hazard stall and applies bubble insertion on flush.
- Sits between the IF/ID register and the datapath stage muxes.

Parameters:
- ALUOP_W, 3, width of the alu_op field; minimum 3; upper bits zero-extended.
- REG_AW, 5, register address width.
- CTRL_W, 11+ALUOP_W, bundle width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction; 0 decodes as a bubble
- id_opcode  in  7  instr[6:0]
- id_rs1  in  REG_AW  instr[19:15]
- id_rs2  in  REG_AW  instr[24:20]
- id_rd  in  REG_AW  instr[11:7]
- flush  in  1  branch/jump taken in EX; squash the instruction in ID
- stall_ext  in  1  memory wait; freeze all three registers
- hazard_stall  out  1  load-use detected (combinational)
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W  registered bundles
- ex_rd, mem_rd, wb_rd  out  REG_AW  registered destination registers

Behaviour:
- Bundle bit order, MSB to LSB: illegal, pc_rel, upper, jalr, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op[ALUOP_W-1:0].
- Decode is combinational. Field order below is alu_src, m2r, rw, mr, mw, br, j; then alu_op; then flags:
  - R 0110011: 0010000; alu_op 010
  - load 0000011: 1111000; alu_op 000
  - store 0100011: 1000100; alu_op 000
  - branch 1100011: 0000010; alu_op 001
  - I-alu 0010011: 1010000; alu_op 011
  - jalr 1100111: 1010001; alu_op 000; jalr=1
  - jal 1101111: 1010001; alu_op 000
  - lui 0110111: 1010000; alu_op 100; upper=1
  - auipc 0010111: 1010000; alu_op 000; pc_rel=1
  - any other opcode: all fields 0 except illegal=1
- Decoded output never contains X.
- Bubble: bundle all 0 and rd=0. Produced when id_valid=0, flush=1, or hazard_stall=1.
- rs usage:
  - rs1 is used by R, I-alu, load, store, branch, jalr.
  - rs2 is used by R, store, branch.
- hazard_stall = id_valid & ex_ctrl.mem_read & (ex_rd!=0) & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- pc_we = ifid_we = ~stall_ext & ~(hazard_stall & ~flush).
- Register update priority, per clock edge:
  1. stall_ext=1: all registers hold; flush and hazard are ignored that cycle. The requester keeps flush asserted until stall_ext drops.
  2. Otherwise ID/EX loads the bubble if flush | hazard_stall | ~id_valid, else the decoded bundle and id_rd. EX/MEM loads ID/EX; MEM/WB loads EX/MEM.
- flush with hazard_stall in the same cycle: flush wins. A bubble is inserted and PC/IF-ID are enabled so the redirect proceeds.
- Latency: decode to ex_ctrl is 1 cycle, to mem_ctrl 2 cycles, to wb_ctrl 3 cycles.
- A load-use stall lasts exactly 1 cycle: after the bubble, ex_ctrl.mem_read=0.
- Reset: asynchronous assertion clears all three registers to the bubble (ctrl 0, rd 0).
  - hazard_stall=0 after reset; pc_we=ifid_we=1 unless stall_ext=1.
  - Deassertion is consumed at the next clk edge. Reset mid-stall discards in-flight instructions.
- An illegal instruction propagates to wb_ctrl.illegal with reg_write, mem_write, branch and jump all 0, so it has no architectural side effect.

Test Plan:
- Reset with stall_ext=0: pulse rst_n low mid-cycle with a load in flight -> ex/mem/wb_ctrl and rd become 0 immediately; hazard_stall=0; pc_we=1.
- Decode sweep: each of the 9 opcodes with id_valid=1 -> ex_ctrl equals the table one cycle later. Example: lui gives upper=1, alu_op=100, reg_write=1. Opcode 1111111 gives only illegal=1.
- Load-use: lw x5 then add x6,x5,x7 -> hazard_stall=1 and pc_we=ifid_we=0 for one cycle; ex_ctrl bubble; the add reaches ex_ctrl next cycle. Also: lui x5 after lw x5 -> no stall; lw x0 followed by a user of x0 -> no stall.
- Flush: flush=1 with a valid R-type in ID -> ex_ctrl=0 next cycle. flush plus hazard together -> bubble, and pc_we=1.
- stall_ext=1 for 3 cycles with instructions in all stages -> all outputs hold their values. Releasing it resumes the 1/2/3-cycle progression with nothing lost or duplicated.
- Back-to-back stream: lw, sw, beq, jal, auipc -> each bundle appears at wb_ctrl exactly 3 cycles after issue, in order.
